weight_seq_ctrl: RTL and testbench

WEIGHT_SEQ_CTRL -- requirements
Module: weight_seq_ctrl

---
 rtl/weight_pkg.sv | 24 ++
 rtl/wctrl_arb.sv | 52 +++++
 rtl/weight_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_weight_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// rtl/weight_pkg.sv - shared types and defaults for the weight RAM sequencing controller
//
// Purpose : FSM state encoding, requester identifiers and default geometry
//           for weight_seq_ctrl and its arbiter wctrl_arb.
// Contents: WP_N, WP_DEPTH, WP_ADDR_W defaults; state_t; req_id_t.
package weight_pkg;

    localparam int WP_N      = 10;
    localparam int WP_DEPTH  = 65;
    localparam int WP_ADDR_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Bit position of each requester in the request/grant vectors.
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_t;

endpackage

// File: rtl/wctrl_arb.sv
// rtl/wctrl_arb.sv - two-requester arbiter for the weight RAM port
//
// Purpose : picks one of the read/write requesters, one-hot grant out.
// Config  : WCTRL_RR_ARB_EN defined -> round-robin, last winner loses a tie;
//           undefined -> fixed priority, write over read.
// Ports   : clk_i, rst_i, accept_i (round-robin build only) - pointer clock,
//           sync active-high reset, and "grant was taken" strobe
//           req_i[1:0]  - {wr, rd} requests
//           gnt_o[1:0]  - {wr, rd} one-hot grant (combinational)
module wctrl_arb
    import weight_pkg::*;
(
`ifdef WCTRL_RR_ARB_EN
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       accept_i,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef WCTRL_RR_ARB_EN
    req_id_t last_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == REQ_WR) ? 2'b01 : 2'b10;
        end
    end

    // Reset to "read won last" so the first tie goes to the writer,
    // matching the fixed-priority build's first decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= REQ_RD;
        end else if (accept_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1] ? REQ_WR : REQ_RD;
        end
    end
`else
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[1]) begin
            gnt_o[1] = 1'b1;
        end else if (req_i[0]) begin
            gnt_o[0] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/weight_seq_ctrl.sv
// rtl/weight_seq_ctrl.sv - weight RAM sweep/burst sequencing controller
//
// Purpose : runs a DEPTH-cycle random-fill sweep of the weight RAM on
//           init_req_i, otherwise arbitrates inference reads and trainer
//           writes into single-cycle RAM accesses with range checking.
// Config  : WCTRL_RR_ARB_EN selects round-robin arbitration (see wctrl_arb).
// Ports   : clk_i, rst_i (sync, active-high)
//           init_req_i / init_busy_o / init_done_o - sweep control
//           rd_req_i, rd_addr_i, wr_req_i, wr_addr_i - burst requests
//           rd_gnt_o, wr_gnt_o, rd_valid_o, addr_err_o - access status
//           ram_in_o, ram_we_o, ram_addr_o           - RAM controls
module weight_seq_ctrl
    import weight_pkg::*;
#(
    parameter int N      = WP_N,
    parameter int DEPTH  = WP_DEPTH,
    parameter int ADDR_W = WP_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_req_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              rd_gnt_o,
    output logic              wr_gnt_o,
    output logic              rd_valid_o,
    output logic              addr_err_o,
    output logic              ram_in_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o
);

    localparam logic [ADDR_W-1:0] CNT_LAST = (ADDR_W)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   BURST_N  = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_busy_q, init_done_q;
    logic              rd_gnt_q, wr_gnt_q, rd_valid_q, addr_err_q;
    logic              ram_in_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;

    logic [1:0]        gnt_d;
    logic              accept_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [ADDR_W:0]   burst_end_d;
    logic              err_d;

    // Grants are only taken in IDLE and only when no sweep is being started.
    assign accept_d = (state_q == ST_IDLE) && !init_req_i;

    wctrl_arb u_arb (
`ifdef WCTRL_RR_ARB_EN
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .accept_i (accept_d),
`endif
        .req_i    ({wr_req_i, rd_req_i}),
        .gnt_o    (gnt_d)
    );

    // One extra bit so base+N cannot wrap before the compare.
    assign win_addr_d  = gnt_d[1] ? wr_addr_i : rd_addr_i;
    assign burst_end_d = {1'b0, win_addr_d} + BURST_N;
    assign err_d       = burst_end_d > DEPTH_W;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            ram_in_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
        end else begin
            // Pulses default low every cycle.
            init_done_q <= 1'b0;
            rd_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_req_i) begin
                        state_q     <= ST_INIT;
                        cnt_q       <= '0;
                        init_busy_q <= 1'b1;
                        ram_in_q    <= 1'b1;
                    end else if (gnt_d != 2'b00) begin
                        state_q    <= ST_ACCESS;
                        rd_gnt_q   <= gnt_d[0];
                        wr_gnt_q   <= gnt_d[1];
                        ram_addr_q <= win_addr_d;
                        ram_we_q   <= gnt_d[1] && !err_d;
                        addr_err_q <= err_d;
                    end
                end
                ST_INIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_IDLE;
                        init_busy_q <= 1'b0;
                        ram_in_q    <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // RAM Q carries the burst one cycle after the issue cycle.
                    state_q    <= ST_IDLE;
                    rd_valid_q <= rd_gnt_q && !addr_err_q;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_busy_o = init_busy_q;
    assign init_done_o = init_done_q;
    assign rd_gnt_o    = rd_gnt_q;
    assign wr_gnt_o    = wr_gnt_q;
    assign rd_valid_o  = rd_valid_q;
    assign addr_err_o  = addr_err_q;
    assign ram_in_o    = ram_in_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb/tb_weight_seq_ctrl.sv - self-checking bench for weight_seq_ctrl
module tb_weight_seq_ctrl;

    localparam int N      = 10;
    localparam int DEPTH  = 65;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              init_req_i = 1'b0;
    logic              init_busy_o, init_done_o;
    logic              rd_req_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_i = '0;
    logic              wr_req_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic              rd_gnt_o, wr_gnt_o, rd_valid_o, addr_err_o;
    logic              ram_in_o, ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;

    weight_seq_ctrl #(.N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .init_req_i  (init_req_i),
        .init_busy_o (init_busy_o),
        .init_done_o (init_done_o),
        .rd_req_i    (rd_req_i),
        .rd_addr_i   (rd_addr_i),
        .wr_req_i    (wr_req_i),
        .wr_addr_i   (wr_addr_i),
        .rd_gnt_o    (rd_gnt_o),
        .wr_gnt_o    (wr_gnt_o),
        .rd_valid_o  (rd_valid_o),
        .addr_err_o  (addr_err_o),
        .ram_in_o    (ram_in_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit wr;
        int addr;
        bit err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   exp_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit wr, input int addr);
        exp_t e;
        e.wr   = wr;
        e.addr = addr;
        e.err  = (addr + N) > DEPTH;
        q.push_back(e);
    endtask

    // Advance one clock, then check grant/valid traffic against the scoreboard.
    task automatic tick();
        exp_t e;
        bit   rst_seen;
        rst_seen = rst_i;
        @(posedge clk);
        #1;
        if (rst_seen) exp_valid = 1'b0;
        chk("rd_valid", rd_valid_o, exp_valid);
        exp_valid = 1'b0;
        if (rd_gnt_o || wr_gnt_o) begin
            if (q.size() == 0) begin
                chk("unexpected_gnt", {rd_gnt_o, wr_gnt_o}, 2'b00);
            end else begin
                e = q.pop_front();
                chk("gnt_wr",   wr_gnt_o, e.wr);
                chk("gnt_rd",   rd_gnt_o, !e.wr);
                chk("gnt_addr", ram_addr_o, e.addr);
                chk("gnt_we",   ram_we_o, e.wr && !e.err);
                chk("gnt_err",  addr_err_o, e.err);
                chk("gnt_ramin", ram_in_o, 1'b0);
                exp_valid = !e.wr && !e.err;
            end
        end else begin
            chk("idle_we",  ram_we_o, 1'b0);
            chk("idle_err", addr_err_o, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, init_busy_o, 1'b0);
        chk({tag, "_done"}, init_done_o, 1'b0);
        chk({tag, "_rdgnt"}, rd_gnt_o, 1'b0);
        chk({tag, "_wrgnt"}, wr_gnt_o, 1'b0);
        chk({tag, "_rdval"}, rd_valid_o, 1'b0);
        chk({tag, "_err"}, addr_err_o, 1'b0);
        chk({tag, "_ramin"}, ram_in_o, 1'b0);
        chk({tag, "_we"}, ram_we_o, 1'b0);
        chk({tag, "_addr"}, ram_addr_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_i = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Sweep; init_req outranks a simultaneous rd_req, which then waits out INIT
        init_req_i = 1'b1;
        rd_req_i   = 1'b1;
        rd_addr_i  = 7'd20;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            init_req_i = (i == 10); // re-request mid-sweep must be ignored
            chk("init_busy", init_busy_o, 1'b1);
            chk("init_ramin", ram_in_o, 1'b1);
            chk("init_done_early", init_done_o, 1'b0);
        end
        init_req_i = 1'b0;
        tick();
        chk("init_done_pulse", init_done_o, 1'b1);
        chk("init_ramin_end", ram_in_o, 1'b0);
        chk("init_busy_end", init_busy_o, 1'b0);

        // Pending read at address 20 issues now, rd_valid follows
        push_exp(1'b0, 20);
        tick();
        chk("init_done_once", init_done_o, 1'b0);
        chk("rd20_gnt", rd_gnt_o, 1'b1);
        rd_req_i = 1'b0;
        tick();
        chk("rd20_valid", rd_valid_o, 1'b1);
        tick();

        // Contention, both held across four grants
        wr_addr_i = 7'd0;
        rd_addr_i = 7'd10;
`ifdef WCTRL_RR_ARB_EN
        push_exp(1'b1, 0);
        push_exp(1'b0, 10);
        push_exp(1'b1, 0);
        push_exp(1'b0, 10);
`else
        for (int i = 0; i < 4; i++) push_exp(1'b1, 0);
`endif
        rd_req_i = 1'b1;
        wr_req_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        chk("arb_all_granted", q.size(), 0);
        tick();
        tick();

        // Range boundary: base 56 errors, base 55 fits exactly
        wr_addr_i = 7'd56;
        push_exp(1'b1, 56);
        wr_req_i = 1'b1;
        tick();
        chk("wr56_err", addr_err_o, 1'b1);
        wr_req_i = 1'b0;
        tick();
        tick();
        wr_addr_i = 7'd55;
        push_exp(1'b1, 55);
        wr_req_i = 1'b1;
        tick();
        chk("wr55_we", ram_we_o, 1'b1);
        wr_req_i = 1'b0;
        tick();
        tick();
        rd_addr_i = 7'd60;
        push_exp(1'b0, 60);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        tick();
        chk("rd60_novalid", rd_valid_o, 1'b0);
        tick();

        // Reset at sweep cycle 30 aborts the sweep
        init_req_i = 1'b1;
        tick();
        init_req_i = 1'b0;
        for (int i = 1; i < 30; i++) tick();
        chk("abort_busy_before", init_busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        check_all_zero("abort_init");
        rst_i = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            chk("abort_no_done", init_done_o, 1'b0);
            chk("abort_no_ramin", ram_in_o, 1'b0);
        end

        // Reset in the access cycle suppresses rd_valid
        rd_addr_i = 7'd20;
        push_exp(1'b0, 20);
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk("abort_access_valid", rd_valid_o, 1'b0);
        rst_i = 1'b0;
        tick();
        tick();

        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
